alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Queued ALU sequencer: strobed commands load {opcode, operand} entries into a FIFO,
// and a RUN command replays the entries through an 8-bit accumulator, one entry per cycle.
module alu_seq_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_RUN   = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              acc_q, acc_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic                    stb_q;
  logic [DEPTH-1:0][10:0]  mem_q;
  logic                    push;

  logic [1:0] cmd;
  logic [2:0] op_in;
  logic       accept, full, empty;
  logic [2:0] head_op;
  logic [7:0] head_opd, alu_res;
  logic       unused_bits;

  assign cmd         = ui_in[7:6];
  assign op_in       = ui_in[2:0];
  assign accept      = ui_in[5] & ~stb_q;
  assign full        = (cnt_q == CW'(DEPTH));
  assign empty       = (cnt_q == '0);
  assign head_op     = mem_q[rd_q][10:8];
  assign head_opd    = mem_q[rd_q][7:0];
  assign unused_bits = ui_in[3];

  always_comb begin
    alu_res = acc_q;
    case (head_op)
      3'd0: alu_res = acc_q + head_opd;
      3'd1: alu_res = acc_q - head_opd;
      3'd2: alu_res = acc_q & head_opd;
      3'd3: alu_res = acc_q | head_opd;
      3'd4: alu_res = acc_q ^ head_opd;
      3'd5: alu_res = {acc_q[6:0], 1'b0};
      3'd6: alu_res = {1'b0, acc_q[7:1]};
      3'd7: alu_res = {7'd0, (acc_q < head_opd)};
      default: alu_res = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    push    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (accept && cmd == CMD_CLEAR) begin
          // Abort wins over the ALU step scheduled for this cycle.
          state_d = S_IDLE;
          acc_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          rd_d    = '0;
          wr_d    = '0;
        end else begin
          if (accept && cmd != CMD_NOP) err_d = 1'b1;
          if (empty) begin
            state_d = S_DONE;
          end else begin
            acc_d = alu_res;
            rd_d  = rd_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_DONE;
          end
        end
      end
      default: begin
        if (accept) begin
          state_d = S_IDLE;
          case (cmd)
            CMD_LOAD: begin
              if (full) begin
                err_d = 1'b1;
              end else begin
                push  = 1'b1;
                wr_d  = wr_q + 1'b1;
                cnt_d = cnt_q + 1'b1;
              end
            end
            CMD_CLEAR: begin
              acc_d = '0;
              err_d = 1'b0;
              cnt_d = '0;
              rd_d  = '0;
              wr_d  = '0;
            end
            CMD_RUN: state_d = empty ? S_DONE : S_RUN;
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      stb_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      stb_q   <= ui_in[5];
    end
  end

  // Entry storage needs no reset: occupancy is tracked by cnt_q and the pointers.
  always_ff @(posedge clk) begin
    if (ena && push) mem_q[wr_q] <= {op_in, uio_in};
  end

  assign uo_out  = ui_in[4] ? {state_q == S_RUN, state_q == S_DONE, full, empty, err_q, cnt_q[2:0]}
                            : acc_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Random and directed stimulus for alu_seq_ctrl, checked against a queue-based reference model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 finished.
  logic [10:0] q[$];
  int          m_acc, m_phase;
  bit          m_err, m_stb;

  function automatic logic [7:0] ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a * 2) % 256;
      6: r = a / 2;
      default: r = (a < b) ? 1 : 0;
    endcase
    return 8'(r);
  endfunction

  function automatic logic [7:0] m_status();
    int n = q.size();
    logic [2:0] lo = n[2:0];
    return {m_phase == 1, m_phase == 2, n == 8, n == 0, m_err, lo};
  endfunction

  task automatic m_reset();
    q.delete();
    m_acc = 0; m_phase = 0; m_err = 0; m_stb = 0;
  endtask

  task automatic m_clear();
    q.delete();
    m_acc = 0; m_err = 0; m_phase = 0;
  endtask

  task automatic m_step(input logic e, input logic [7:0] ui, input logic [7:0] d);
    bit acc_cmd;
    int c;
    logic [10:0] it;
    if (!e) return;
    acc_cmd = ui[5] && !m_stb;
    m_stb   = ui[5];
    c       = int'(ui[7:6]);
    if (m_phase == 1) begin
      if (acc_cmd && c == 3) m_clear();
      else begin
        if (acc_cmd && c != 0) m_err = 1;
        it = q.pop_front();
        m_acc = int'(ref_alu(int'(it[10:8]), m_acc, int'(it[7:0])));
        if (q.size() == 0) m_phase = 2;
      end
    end else if (acc_cmd) begin
      m_phase = 0;
      case (c)
        1: if (q.size() == 8) m_err = 1; else q.push_back({ui[2:0], d});
        2: m_phase = (q.size() == 0) ? 2 : 1;
        3: m_clear();
        default: ;
      endcase
    end
  endtask

  task automatic peek(output logic [7:0] ac, output logic [7:0] st);
    logic [7:0] sv = ui_in;
    ui_in[4] = 1'b0; #1 ac = uo_out;
    ui_in[4] = 1'b1; #1 st = uo_out;
    ui_in = sv;
  endtask

  task automatic cycle(input logic e, input logic [7:0] ui, input logic [7:0] d);
    logic [7:0] ac, st;
    ena = e; ui_in = ui; uio_in = d;
    @(posedge clk);
    m_step(e, ui, d);
    #1 peek(ac, st);
    chk("acc", ac, 8'(m_acc));
    chk("status", st, m_status());
    chk("uio_out", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'h00);
  endtask

  task automatic async_reset();
    logic [7:0] ac, st;
    rst_n = 1'b0;
    #1 m_reset();
    peek(ac, st);
    chk("rst_acc", ac, 8'h00);
    chk("rst_status", st, 8'h10);
    chk("rst_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [2:0] op, input logic [7:0] d);
    cycle(1'b1, {c, 1'b1, 2'b00, op}, d);
    cycle(1'b1, {c, 1'b0, 2'b00, op}, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] ac, st;
    int busy_n;
    m_reset();
    @(negedge clk);
    async_reset();
    idle(2);

    // Three-entry program: 0+05, +FF, -02
    issue(2'b11, 3'd0, 8'h00);
    issue(2'b01, 3'd0, 8'h05);
    issue(2'b01, 3'd0, 8'hFF);
    issue(2'b01, 3'd1, 8'h02);
    peek(ac, st); chk("prog_pre_run", st, 8'h03);
    issue(2'b10, 3'd0, 8'h00);
    peek(ac, st); chk("prog_acc1", ac, 8'h05);
    idle(1); peek(ac, st); chk("prog_acc2", ac, 8'h04);
    idle(1); peek(ac, st); chk("prog_acc3", ac, 8'h02); chk("prog_done", st, 8'h50);

    // Overfill then count busy cycles
    async_reset();
    for (int i = 0; i < 9; i++) issue(2'b01, 3'd4, 8'(i + 1));
    peek(ac, st); chk("full_err", st, 8'h28);
    cycle(1'b1, 8'b1010_0000, 8'h00);
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      peek(ac, st);
      if (st[7]) busy_n++;
      cycle(1'b1, 8'h00, 8'h00);
    end
    chk("busy_cycles", 8'(busy_n), 8'd8);

    // Compare, shift-left, shift-right
    issue(2'b11, 3'd0, 8'h00);
    issue(2'b01, 3'd0, 8'h03); issue(2'b10, 3'd0, 8'h00); idle(1);
    issue(2'b01, 3'd7, 8'h04); issue(2'b10, 3'd0, 8'h00); idle(1);
    peek(ac, st); chk("op_lt", ac, 8'h01);
    issue(2'b11, 3'd0, 8'h00);
    issue(2'b01, 3'd0, 8'h80); issue(2'b10, 3'd0, 8'h00); idle(1);
    issue(2'b01, 3'd5, 8'h3C); issue(2'b10, 3'd0, 8'h00); idle(1);
    peek(ac, st); chk("op_shl", ac, 8'h00);
    issue(2'b11, 3'd0, 8'h00);
    issue(2'b01, 3'd0, 8'h81); issue(2'b10, 3'd0, 8'h00); idle(1);
    issue(2'b01, 3'd6, 8'hA5); issue(2'b10, 3'd0, 8'h00); idle(1);
    peek(ac, st); chk("op_shr", ac, 8'h40);

    // Abort in second RUN cycle, then LOAD during RUN
    issue(2'b11, 3'd0, 8'h00);
    for (int i = 0; i < 5; i++) issue(2'b01, 3'd0, 8'h01);
    issue(2'b10, 3'd0, 8'h00);
    issue(2'b11, 3'd0, 8'h00);
    peek(ac, st); chk("abort_acc", ac, 8'h00); chk("abort_status", st, 8'h10);
    idle(3);
    for (int i = 0; i < 3; i++) issue(2'b01, 3'd0, 8'h01);
    issue(2'b10, 3'd0, 8'h00);
    issue(2'b01, 3'd0, 8'h07);
    idle(2);
    peek(ac, st); chk("run_load_err", st, 8'h58);

    // Reset mid-run discards remaining entries
    issue(2'b11, 3'd0, 8'h00);
    for (int i = 0; i < 5; i++) issue(2'b01, 3'd0, 8'h09);
    issue(2'b10, 3'd0, 8'h00);
    async_reset();
    idle(4);

    // Held strobe, then ena freeze mid-run
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'b0110_0000, 8'h11);
    peek(ac, st); chk("held_strobe", st, 8'h01);
    cycle(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) issue(2'b01, 3'd0, 8'h02);
    issue(2'b10, 3'd0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'b1010_0000, 8'h00);
    idle(5);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] c = (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : (r < 8) ? 2'b11 : 2'b00;
      logic [7:0] u = {c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
      cycle(1'($urandom_range(0, 9) != 0), u, 8'($urandom));
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
